// File: rtl/reverb_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// reverb_mul_arbiter_if
// Bundles the two requester channels and the response channel of the shared
// multiplier controller.
//   req0_* / req1_* : valid/ready request channels carrying 32-bit operands
//   rsp_*           : valid/ready response channel, 32-bit product + id
// Modports:
//   master : requester/consumer side (drives requests, accepts responses)
//   slave  : controller side (reverb_mul_arbiter)
// ---------------------------------------------------------------------------
interface reverb_mul_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/reverb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// reverb_mul_arbiter
// Shares one 32x32 partial-product multiplier cell between two requesters.
// Round-robin arbitration, a three-stage stallable pipeline (E -> cell/M ->
// W) and a valid/ready response carrying (a*b) mod 2^32 plus requester id.
//
// Ports:
//   i_clk, i_reset_n        : clock, synchronous active-low reset
//   io_bus (slave modport)  : req0/req1 request channels, response channel
//   o_cell_src1/2, o_cell_en: operands and pipeline enable for the cell
//   i_cell_p1/p2/p3         : registered partial products lo*lo, lo*hi, hi*lo
//   o_cnt0, o_cnt1          : accepted-request counters
// Parameters:
//   CNT_W   : counter width
//   RR_INIT : requester favoured after reset
// Configuration macro:
//   REVERB_MUL_ARB_CNT_EN : builds saturating accept counters; when undefined
//                           the counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module reverb_mul_arbiter #(
    parameter int CNT_W   = 16,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    reverb_mul_arbiter_if.slave   io_bus,
    output logic [31:0]           o_cell_src1,
    output logic [31:0]           o_cell_src2,
    output logic                  o_cell_en,
    input  logic [31:0]           i_cell_p1,
    input  logic [31:0]           i_cell_p2,
    input  logic [31:0]           i_cell_p3,
    output logic [CNT_W-1:0]      o_cnt0,
    output logic [CNT_W-1:0]      o_cnt1
);

    logic        r_ptr;
    logic        r_e_v;
    logic        r_e_id;
    logic [31:0] r_e_a;
    logic [31:0] r_e_b;
    logic        r_m_v;
    logic        r_m_id;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_data;

    logic        w_stall;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc0;
    logic        w_acc1;
    logic [31:0] w_prod;

    // A held response freezes every stage, including the cell register.
    assign w_stall = r_rsp_valid & ~io_bus.rsp_ready;

    // A lone requester always wins; the pointer only breaks ties.
    assign w_gnt0 = io_bus.req0_valid & (~io_bus.req1_valid | ~r_ptr);
    assign w_gnt1 = io_bus.req1_valid & (~io_bus.req0_valid |  r_ptr);

    assign io_bus.req0_ready = ~w_stall & w_gnt0;
    assign io_bus.req1_ready = ~w_stall & w_gnt1;

    assign w_acc0 = io_bus.req0_valid & io_bus.req0_ready;
    assign w_acc1 = io_bus.req1_valid & io_bus.req1_ready;

    assign o_cell_src1 = r_e_a;
    assign o_cell_src2 = r_e_b;
    assign o_cell_en   = ~w_stall;

    // hi*hi would land at bit 32 and is dropped, so three products suffice.
    assign w_prod = i_cell_p1 + ((i_cell_p2 + i_cell_p3) << 5'd16);

    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_id    = r_rsp_id;
    assign io_bus.rsp_data  = r_rsp_data;

    // Arbitration pointer and E/M/W pipeline registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_ptr       <= RR_INIT;
            r_e_v       <= 1'b0;
            r_e_id      <= 1'b0;
            r_e_a       <= 32'h0000_0000;
            r_e_b       <= 32'h0000_0000;
            r_m_v       <= 1'b0;
            r_m_id      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= 32'h0000_0000;
        end else if (!w_stall) begin
            // Operands only load on accept; e_v alone qualifies them.
            r_e_v <= w_acc0 | w_acc1;
            if (w_acc0 | w_acc1) begin
                r_e_id <= w_acc1;
                r_e_a  <= w_acc1 ? io_bus.req1_a : io_bus.req0_a;
                r_e_b  <= w_acc1 ? io_bus.req1_b : io_bus.req0_b;
                r_ptr  <= ~w_acc1;
            end else begin
                r_e_id <= r_e_id;
                r_e_a  <= r_e_a;
                r_e_b  <= r_e_b;
                r_ptr  <= r_ptr;
            end
            r_m_v       <= r_e_v;
            r_m_id      <= r_e_id;
            r_rsp_valid <= r_m_v;
            r_rsp_id    <= r_m_id;
            r_rsp_data  <= w_prod;
        end else begin
            r_ptr       <= r_ptr;
            r_e_v       <= r_e_v;
            r_e_id      <= r_e_id;
            r_e_a       <= r_e_a;
            r_e_b       <= r_e_b;
            r_m_v       <= r_m_v;
            r_m_id      <= r_m_id;
            r_rsp_valid <= r_rsp_valid;
            r_rsp_id    <= r_rsp_id;
            r_rsp_data  <= r_rsp_data;
        end
    end

`ifdef REVERB_MUL_ARB_CNT_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Saturating per-requester accept counters.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt0 <= {CNT_W{1'b0}};
            r_cnt1 <= {CNT_W{1'b0}};
        end else begin
            if (w_acc0 && (r_cnt0 != {CNT_W{1'b1}})) begin
                r_cnt0 <= r_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt0 <= r_cnt0;
            end
            if (w_acc1 && (r_cnt1 != {CNT_W{1'b1}})) begin
                r_cnt1 <= r_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt1 <= r_cnt1;
            end
        end
    end

    assign o_cnt0 = r_cnt0;
    assign o_cnt1 = r_cnt1;
`else
    assign o_cnt0 = {CNT_W{1'b0}};
    assign o_cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_reverb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reverb_mul_arbiter
// Drives reverb_mul_arbiter with directed and random traffic. A behavioural
// model of the multiplier cell sits beside the DUT; the reference is a queue
// of accepted requests, each carrying its product (computed with a 64-bit
// multiply) and its age in un-stalled cycles. Age 3 means "in the response
// register".
// ---------------------------------------------------------------------------
module tb_reverb_mul_arbiter;
`ifdef REVERB_MUL_ARB_CNT_EN
    localparam int CNT_W  = 2;
    localparam bit CNT_ON = 1'b1;
`else
    localparam int CNT_W  = 16;
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      cell_src1, cell_src2;
    logic             cell_en;
    logic [31:0]      cell_p1, cell_p2, cell_p3;
    logic [CNT_W-1:0] cnt0, cnt1;

    reverb_mul_arbiter_if bus();

    reverb_mul_arbiter #(.CNT_W(CNT_W), .RR_INIT(1'b0)) dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .io_bus     (bus),
        .o_cell_src1(cell_src1),
        .o_cell_src2(cell_src2),
        .o_cell_en  (cell_en),
        .i_cell_p1  (cell_p1),
        .i_cell_p2  (cell_p2),
        .i_cell_p3  (cell_p3),
        .o_cnt0     (cnt0),
        .o_cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    // Partial-product cell model: registered lo*lo, lo*hi, hi*lo.
    always @(posedge clk) begin
        if (!reset_n) begin
            cell_p1 <= 32'h0;
            cell_p2 <= 32'h0;
            cell_p3 <= 32'h0;
        end else if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
    end

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        int          age;
    } item_t;

    item_t q[$];
    int    fav = 0;
    int    m_cnt0 = 0;
    int    m_cnt1 = 0;
    int    n_tests = 0;
    int    n_fail = 0;

    logic        last_valid, last_id, last_rdy0, last_rdy1, last_en;
    logic [31:0] last_data;
    logic [31:0] last_cnt0, last_cnt1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, sample/compare against the model, advance model.
    task automatic cyc(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr, input logic rn, input bit chk);
        bit    ev, st, g0, g1;
        item_t it;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready  = rr;
        reset_n        = rn;
        #1;
        last_valid = bus.rsp_valid;
        last_id    = bus.rsp_id;
        last_data  = bus.rsp_data;
        last_rdy0  = bus.req0_ready;
        last_rdy1  = bus.req1_ready;
        last_en    = cell_en;
        last_cnt0  = 32'(cnt0);
        last_cnt1  = 32'(cnt1);

        ev = (q.size() > 0) && (q[0].age >= 3);
        st = ev && !rr;
        g0 = v0 && (!v1 || fav == 0);
        g1 = v1 && (!v0 || fav == 1);

        if (chk) begin
            check("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
            if (ev) begin
                check("rsp_data", bus.rsp_data, q[0].prod);
                check("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
            end
            check("cell_en", 32'(cell_en), 32'(!st));
            check("req0_ready", 32'(bus.req0_ready), 32'(g0 && !st));
            check("req1_ready", 32'(bus.req1_ready), 32'(g1 && !st));
            foreach (q[i]) begin
                if (q[i].age == 1) begin
                    check("cell_src1", cell_src1, q[i].a);
                    check("cell_src2", cell_src2, q[i].b);
                end
            end
            check("cnt0", 32'(cnt0), CNT_ON ? 32'(m_cnt0) : 32'h0);
            check("cnt1", 32'(cnt1), CNT_ON ? 32'(m_cnt1) : 32'h0);
        end

        if (!rn) begin
            q.delete();
            fav = 0;
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else if (!st) begin
            if (ev) void'(q.pop_front());
            if (g0 || g1) begin
                it.id   = g1;
                it.a    = g1 ? a1 : a0;
                it.b    = g1 ? b1 : b0;
                it.prod = 32'(64'(it.a) * 64'(it.b));
                it.age  = 0;
                q.push_back(it);
                fav = g1 ? 0 : 1;
                if (g0 && m_cnt0 < (2**CNT_W) - 1) m_cnt0++;
                if (g1 && m_cnt1 < (2**CNT_W) - 1) m_cnt1++;
            end
            foreach (q[i]) q[i].age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    endtask

    logic [31:0] held;

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = 32'h0; bus.req0_b = 32'h0;
        bus.req1_a = 32'h0; bus.req1_b = 32'h0;
        bus.rsp_ready = 1'b1;

        // Power-on reset (DUT state unknown before the first edge).
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset state.
        idle(1);
        check("reset_rsp_valid", 32'(last_valid), 32'h0);
        check("reset_cell_en", 32'(last_en), 32'h1);
        check("reset_cell_src1", cell_src1, 32'h0);
        check("reset_cell_src2", cell_src2, 32'h0);

        // Single req0 request: three-cycle latency.
        cyc(1'b1, 32'h0003_0004, 32'h0005_0006, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("single_ready0", 32'(last_rdy0), 32'h1);
        idle(2);
        check("single_not_early", 32'(last_valid), 32'h0);
        idle(1);
        check("single_valid", 32'(last_valid), 32'h1);
        check("single_data", last_data, 32'h0026_0018);
        check("single_id", 32'(last_id), 32'h0);
        idle(2);

        // req1 all-ones operands.
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        idle(3);
        check("ones_data", last_data, 32'h0000_0001);
        check("ones_id", 32'(last_id), 32'h1);
        idle(1);

        // 2^16 * 2^16 wraps to zero.
        cyc(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        idle(3);
        check("wrap_valid", 32'(last_valid), 32'h1);
        check("wrap_data", last_data, 32'h0000_0000);
        idle(1);

        // Both valid after reset: grants alternate 0,1,0,1,0,1.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b1);
            check("alt_ready0", 32'(last_rdy0), 32'((i % 2) == 0));
            check("alt_ready1", 32'(last_rdy1), 32'((i % 2) == 1));
        end
        idle(5);

        // Back-pressure with three results in flight.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, $urandom, $urandom, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b1);
            if (i == 0) held = last_data;
            check("stall_data", last_data, held);
            check("stall_en", 32'(last_en), 32'h0);
            check("stall_rdy0", 32'(last_rdy0), 32'h0);
            check("stall_rdy1", 32'(last_rdy1), 32'h0);
        end
        idle(5);
        check("stall_drained", 32'(q.size()), 32'h0);

        // Reset with three results in flight.
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 32'h0, 32'h0, 1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("rst_flush_valid", 32'(last_valid), 32'h0);
        idle(3);
        cyc(1'b1, $urandom, $urandom, 1'b1, $urandom, $urandom, 1'b1, 1'b1, 1'b1);
        check("rst_ptr_init", 32'(last_rdy0), 32'h1);
        idle(4);

        // Counters: five req0 accepts from a clean reset.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, $urandom, $urandom, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1);
        check("cnt0_after5", last_cnt0, CNT_ON ? 32'h3 : 32'h0);
        check("cnt1_after5", last_cnt1, 32'h0);
        idle(4);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc(1'($urandom_range(0, 1)), ra, rb,
                1'($urandom_range(0, 1)), $urandom, $urandom,
                1'($urandom_range(0, 3) != 0), 1'b1, 1'b1);
        end
        idle(6);
        check("final_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reverb_mul_arbiter.md
# reverb_mul_arbiter

Controller that shares the Nios II 32x32 multiplier partial-product cell (three registered 16x16 unsigned products p1 = a_lo·b_lo, p2 = a_lo·b_hi, p3 = a_hi·b_lo) between two requesters, e.g. the CPU custom-instruction port and the reverb FIR accelerator. It arbitrates round-robin, drives the cell's operands and enable, combines the partial products into the low 32 bits of the product, and returns the result with the requester's ID over a valid/ready response channel. The pipeline is fully stallable and sustains one multiply per cycle.

## Interface
- CNT_W, 16, width of the per-requester accept counters (CNT feature)
- RR_INIT, 0, requester favoured by the round-robin pointer after reset

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted when valid & ready
- req0_a, req0_b / req1_a, req1_b  in  32  unsigned operands
- rsp_valid  out  1  result available
- rsp_ready  in  1  downstream accepts result
- rsp_data  out  32  (a·b) mod 2^32
- rsp_id  out  1  requester index of rsp_data
- cell_src1, cell_src2  out  32  operands to the multiplier cell
- cell_en  out  1  cell pipeline-register enable
- cell_p1, cell_p2, cell_p3  in  32  registered partial products from the cell
- cnt0, cnt1  out  CNT_W  accepted-request counters

## Operation
- Three stages: E (operand register: e_v, e_id, e_a, e_b), M (the cell's internal register plus controller m_v, m_id), W (response register: rsp_valid, rsp_id, rsp_data).
- stall = rsp_valid & ~rsp_ready. When stall=1, all stages hold and cell_en=0. Otherwise all stages advance: E→M, M→W, accepted request→E.
- cell_src1 = e_a and cell_src2 = e_b, driven directly from the E register. cell_en = ~stall.
- W load: rsp_data ← cell_p1 + ((cell_p2 + cell_p3) << 16), all mod 2^32; rsp_valid ← m_v; rsp_id ← m_id.
- Arbitration: a 1-bit pointer ptr, initialised to RR_INIT.
  - Both requesters valid: grant req[ptr].
  - One requester valid: grant that requester.
  - On an accepted grant, ptr ← ~granted index. ptr holds otherwise.
- reqX_ready = ~stall & grantX. Ready depends combinationally on both valids. At most one ready is high in any cycle.
- No request accepted: the E stage loads e_v=0. Operand registers may hold stale data; e_v gates all downstream validity.
- Reset (reset_n=0 at an edge): e_v=m_v=rsp_valid=0, rsp_id=0, rsp_data=0, e_a=e_b=0, ptr=RR_INIT, cnt0=cnt1=0. Results in flight are discarded. The cell clears asynchronously from the same reset net, so partial products are never used without m_v.
- All outputs after reset: reqX_ready = grantX (high when the requester is valid and favoured, per the arbitration rules), rsp_valid=0, cell_en=1, cell_src=0.

## Timing
- Request accepted at edge t: E is valid in cycle t+1 (cell_en=1, cell captures at edge t+1); M is valid in cycle t+2; rsp_valid is high in cycle t+3. Latency is 3 cycles; throughput is 1 per cycle without stalls.
- While rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id hold stable, both reqX_ready=0, and the cell register holds (cell_en=0).
- A response is released and a new request accepted on the same edge whenever rsp_ready=1.
- Results leave in acceptance order. There is no reordering.

## Configuration
- REVERB_MUL_ARB_CNT_EN defined: cnt0 and cnt1 each increment by 1 on every accepted request from that requester and saturate at 2^CNT_W−1 (no wrap).
- REVERB_MUL_ARB_CNT_EN undefined: the counters are not built and cnt0 = cnt1 = 0 constantly. Ports are always present.

## Test plan
- Single request, req0 a=0x00030004, b=0x00050006 -> rsp_valid exactly 3 cycles after accept, rsp_data=0x00260018, rsp_id=0.
- req1 a=b=0xFFFFFFFF -> rsp_data=0x00000001, rsp_id=1. Also check 0x00010000·0x00010000 -> 0x00000000.
- Both requesters valid for 6 cycles after reset (RR_INIT=0) -> grants alternate 0,1,0,1,0,1. Responses are back-to-back with matching ids and products.
- rsp_ready low for 4 cycles with 3 results in flight -> rsp_data stable, cell_en=0, both ready=0. After release, 3 results emerge in order with no loss or duplication.
- reset_n low for 1 cycle while 3 results are in flight -> rsp_valid=0 the next cycle, no stale response ever emerges, ptr=RR_INIT.
- With REVERB_MUL_ARB_CNT_EN and CNT_W=2: 5 req0 accepts -> cnt0=3 (saturated), cnt1=0. Without the macro, both counters read 0.
